// File: rtl/wddl_pkg.sv
// Shared types and constants for the WDDL dual-rail register bank.
// Phase states, rail-pair encodings and the precharge counter width.
package wddl_pkg;

    typedef enum logic [1:0] {
        WDDL_PRE  = 2'b00,
        WDDL_EVAL = 2'b01,
        WDDL_HOLD = 2'b10
    } wddl_state_t;

    // Rail pair is {true_rail, false_rail}.
    typedef enum logic [1:0] {
        RAIL_SPACER  = 2'b00,
        RAIL_ZERO    = 2'b01,
        RAIL_ONE     = 2'b10,
        RAIL_ILLEGAL = 2'b11
    } rail_pair_t;

    localparam int PRE_CNT_W = $clog2(16);

endpackage

// File: rtl/wddl_phase_ctrl.sv
// Precharge/evaluate/hold phase sequencer for the WDDL register bank.
// Emits the phase enables; the datapath decides when a word is captured.
module wddl_phase_ctrl
    import wddl_pkg::*;
#(
    parameter int PRE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic capture,
    input  logic ready_i,
    output logic prechrg_o,
    output logic ready_o,
    output logic valid_o
);

    localparam logic [PRE_CNT_W-1:0] PRE_LAST = PRE_CNT_W'(PRE_CYCLES - 1);

    wddl_state_t          state, state_next;
    logic [PRE_CNT_W-1:0] pre_cnt, pre_cnt_next;
    // The edge that samples reset release is not part of the first precharge.
    logic                 started;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WDDL_PRE;
            pre_cnt <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            pre_cnt <= pre_cnt_next;
            started <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        pre_cnt_next = pre_cnt;
        prechrg_o    = 1'b0;
        ready_o      = 1'b0;
        valid_o      = 1'b0;
        unique case (state)
            WDDL_PRE: begin
                prechrg_o = 1'b1;
                if (started) begin
                    if (pre_cnt == PRE_LAST) begin
                        pre_cnt_next = '0;
                        state_next   = WDDL_EVAL;
                    end else begin
                        pre_cnt_next = pre_cnt + 1'b1;
                    end
                end
            end
            WDDL_EVAL: begin
                ready_o = 1'b1;
                if (capture) state_next = WDDL_HOLD;
            end
            WDDL_HOLD: begin
                valid_o = 1'b1;
                if (ready_i) state_next = WDDL_PRE;
            end
            default: state_next = WDDL_PRE;
        endcase
    end

endmodule

// File: rtl/wddl_reg_bank.sv
// WDDL dual-rail register bank: WIDTH rail pairs with self-timed precharge,
// valid/ready handshake and a sticky illegal-rail-pair fault flag.
module wddl_reg_bank
    import wddl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRE_CYCLES = 1,
    parameter int DUAL_IN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] dbar_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qbar_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             prechrg_o,
    output logic             fault_o
);

    logic [WIDTH-1:0] rail_lo;
    logic             all_data;
    logic             any_illegal;
    logic             accept;
    logic             capture;

    // Single-rail mode synthesises the false rail, so the checker below sees
    // only data pairs and one capture path serves both modes.
    assign rail_lo = (DUAL_IN != 0) ? dbar_i : ~d_i;

    always_comb begin
        all_data    = 1'b1;
        any_illegal = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            case ({d_i[k], rail_lo[k]})
                RAIL_SPACER:  all_data    = 1'b0;
                RAIL_ILLEGAL: any_illegal = 1'b1;
                default:      ;
            endcase
        end
    end

    assign accept  = valid_i && ready_o;
    assign capture = accept && all_data && !any_illegal;

    wddl_phase_ctrl #(
        .PRE_CYCLES(PRE_CYCLES)
    ) u_phase_ctrl (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .ready_i  (ready_i),
        .prechrg_o(prechrg_o),
        .ready_o  (ready_o),
        .valid_o  (valid_o)
    );

    // Rails return to spacer on the same edge that leaves HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o    <= '0;
            qbar_o <= '0;
        end else if (capture) begin
            q_o    <= d_i;
            qbar_o <= rail_lo;
        end else if (valid_o && ready_i) begin
            q_o    <= '0;
            qbar_o <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_o <= 1'b0;
        end else if (accept && any_illegal) begin
            fault_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wddl_reg_bank.sv
// Bench for wddl_reg_bank: a single-rail and a dual-rail instance checked
// every cycle against a word-level reference model, directed then random.
module tb_wddl_reg_bank;

    localparam int PRE = 2;

    typedef enum int {P_PRE, P_EVAL, P_HOLD} phase_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d  [2];
    logic [7:0] db [2];
    logic       v  [2];
    logic       r  [2];
    logic [7:0] q  [2];
    logic [7:0] qb [2];
    logic       rdy[2];
    logic       vo [2];
    logic       pc [2];
    logic       flt[2];

    int checks = 0;
    int errors = 0;

    // Reference model state, one slot per instance (0 = single-rail, 1 = dual-rail).
    phase_t     m_phase  [2];
    int         m_pre    [2];
    bit         m_started[2];
    bit         m_fault  [2];
    logic [7:0] m_q      [2];
    logic [7:0] m_qb     [2];

    always #5 clk = ~clk;

    wddl_reg_bank #(.WIDTH(8), .PRE_CYCLES(PRE), .DUAL_IN(0)) u_single (
        .clk(clk), .rst(rst), .d_i(d[0]), .dbar_i(db[0]), .valid_i(v[0]),
        .ready_o(rdy[0]), .q_o(q[0]), .qbar_o(qb[0]), .valid_o(vo[0]),
        .ready_i(r[0]), .prechrg_o(pc[0]), .fault_o(flt[0])
    );

    wddl_reg_bank #(.WIDTH(8), .PRE_CYCLES(PRE), .DUAL_IN(1)) u_dual (
        .clk(clk), .rst(rst), .d_i(d[1]), .dbar_i(db[1]), .valid_i(v[1]),
        .ready_o(rdy[1]), .q_o(q[1]), .qbar_o(qb[1]), .valid_o(vo[1]),
        .ready_i(r[1]), .prechrg_o(pc[1]), .fault_o(flt[1])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_phase[i]   = P_PRE;
        m_pre[i]     = 0;
        m_started[i] = 1'b0;
        m_fault[i]   = 1'b0;
        m_q[i]       = 8'h00;
        m_qb[i]      = 8'h00;
    endtask

    // One clock edge of the word-level behaviour, using the inputs held across it.
    task automatic model_step(input int i);
        logic [7:0] eff_db;
        if (!m_started[i]) begin
            m_started[i] = 1'b1;
            return;
        end
        case (m_phase[i])
            P_PRE: begin
                m_pre[i]++;
                if (m_pre[i] == PRE) begin
                    m_pre[i]   = 0;
                    m_phase[i] = P_EVAL;
                end
            end
            P_EVAL: begin
                if (v[i]) begin
                    eff_db = (i == 1) ? db[i] : ~d[i];
                    if ((d[i] & eff_db) != 8'h00) begin
                        m_fault[i] = 1'b1;
                    end else if ((~d[i] & ~eff_db) == 8'h00) begin
                        m_q[i]     = d[i];
                        m_qb[i]    = eff_db;
                        m_phase[i] = P_HOLD;
                    end
                end
            end
            default: begin
                if (r[i]) begin
                    m_phase[i] = P_PRE;
                    m_q[i]     = 8'h00;
                    m_qb[i]    = 8'h00;
                end
            end
        endcase
    endtask

    task automatic check_dut(input int i);
        check($sformatf("dut%0d.q_o", i), q[i], m_q[i]);
        check($sformatf("dut%0d.qbar_o", i), qb[i], m_qb[i]);
        check($sformatf("dut%0d.valid_o", i), 8'(vo[i]), 8'(m_phase[i] == P_HOLD));
        check($sformatf("dut%0d.ready_o", i), 8'(rdy[i]), 8'(m_phase[i] == P_EVAL));
        check($sformatf("dut%0d.prechrg_o", i), 8'(pc[i]), 8'(m_phase[i] == P_PRE));
        check($sformatf("dut%0d.fault_o", i), 8'(flt[i]), 8'(m_fault[i]));
        check($sformatf("dut%0d.rail_overlap", i), q[i] & qb[i], 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else     model_step(i);
        end
        check_dut(0);
        check_dut(1);
    endtask

    // Leave HOLD if needed and wait (bounded) until instance i is in EVAL.
    task automatic wait_eval(input int i);
        v[i] = 1'b0;
        r[i] = 1'b1;
        for (int n = 0; n < 20 && m_phase[i] != P_EVAL; n++) tick();
        check($sformatf("dut%0d.reach_eval", i), 8'(rdy[i]), 8'd1);
        r[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            d[i] = 8'h00; db[i] = 8'h00; v[i] = 1'b0; r[i] = 1'b0;
            model_reset(i);
        end

        // Reset, then idle through the first precharge.
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("pre_after_edge1", 8'(pc[0]), 8'd1);
        tick();
        check("ready_before_edge3", 8'(rdy[0]), 8'd0);
        tick();
        check("ready_on_edge3", 8'(rdy[0]), 8'd1);
        check("idle_spacer", q[0] | qb[0], 8'h00);

        // Single-rail capture; dual-rail word with a spacer pair on bit 4.
        d[0] = 8'hA5; v[0] = 1'b1;
        d[1] = 8'h0F; db[1] = 8'hE0; v[1] = 1'b1;
        tick();
        check("single_q", q[0], 8'hA5);
        check("single_qbar", qb[0], 8'h5A);
        check("dual_spacer_nocapture", 8'(vo[1]), 8'd0);
        check("dual_spacer_nofault", 8'(flt[1]), 8'd0);

        // Completed dual-rail word; second single-rail word must be ignored.
        d[0] = 8'hFF;
        db[1] = 8'hF0;
        tick();
        check("dual_q", q[1], 8'h0F);
        check("dual_qbar", qb[1], 8'hF0);

        // Ten cycles of backpressure on the single-rail instance.
        v[1] = 1'b0; r[1] = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        check("backpressure_q", q[0], 8'hA5);
        check("backpressure_valid", 8'(vo[0]), 8'd1);

        v[0] = 1'b0; r[0] = 1'b1;
        tick();
        check("release_spacer", q[0] | qb[0], 8'h00);
        check("release_prechrg", 8'(pc[0]), 8'd1);
        r[0] = 1'b0;

        // Illegal pair on bit 0, then a legal word with the fault still set.
        wait_eval(1);
        d[1] = 8'h01; db[1] = 8'hFF; v[1] = 1'b1;
        tick();
        check("illegal_fault", 8'(flt[1]), 8'd1);
        check("illegal_stay_eval", 8'(rdy[1]), 8'd1);
        d[1] = 8'h3C; db[1] = 8'hC3;
        tick();
        check("post_fault_q", q[1], 8'h3C);
        check("post_fault_sticky", 8'(flt[1]), 8'd1);
        v[1] = 1'b0;

        // Asynchronous reset while holding 0x3C.
        wait_eval(0);
        d[0] = 8'h3C; v[0] = 1'b1;
        tick();
        check("hold_before_reset", q[0], 8'h3C);
        v[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_q", q[0], 8'h00);
        check("async_qbar", qb[0], 8'h00);
        check("async_valid", 8'(vo[0]), 8'd0);
        check("async_fault", 8'(flt[1]), 8'd0);
        tick();
        rst = 1'b0;

        // Randomised traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                d[i]  = 8'($urandom);
                db[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~d[i];
                if (i == 1 && $urandom_range(0, 7) == 0) db[i] = ~d[i] & 8'($urandom);
                v[i] = 1'($urandom_range(0, 1));
                r[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wddl_reg_bank.md
Name: wddl_reg_bank

Overview:
- Parametrised WDDL dual-rail register bank: the next generation of the single-bit WDDL flip-flop.
- Holds WIDTH bits as complementary rail pairs (q_o/qbar_o).
- Runs its own precharge/evaluate phase sequencer, so callers no longer drive precharge.
- Adds a valid/ready handshake and dual-rail input checking with a sticky fault flag. Sits between WDDL datapath stages in the secure-logic pipeline.

Parameters:
- WIDTH, 8: number of dual-rail bit pairs.
- PRE_CYCLES, 1: clock cycles spent in precharge (spacer) per transfer; legal range 1..15.
- DUAL_IN, 0: 0 = single-rail input (dbar_i ignored, complement generated internally); 1 = dual-rail input (d_i/dbar_i checked).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-high.
- d_i  input  WIDTH  true-rail data in.
- dbar_i  input  WIDTH  false-rail data in; used only when DUAL_IN=1.
- valid_i  input  1  upstream word valid.
- ready_o  output  1  bank can accept a word this cycle.
- q_o  output  WIDTH  true-rail registered output.
- qbar_o  output  WIDTH  false-rail registered output.
- valid_o  output  1  q_o/qbar_o hold an evaluated word.
- ready_i  input  1  downstream accepts the word.
- prechrg_o  output  1  bank is in precharge phase (for chaining downstream stages).
- fault_o  output  1  sticky illegal-rail-pair flag.

Behaviour:
- Reset (async, rst=1): state=PRE, precharge counter=0, q_o=qbar_o=0, valid_o=0, ready_o=0, prechrg_o=1, fault_o=0.
  - Deassertion is sampled on the next clk edge; the first PRE period starts there.
- State PRE:
  - q_o=qbar_o=all-zero spacer; prechrg_o=1; ready_o=0; valid_o=0.
  - Counter increments each cycle.
  - When counter==PRE_CYCLES-1: counter clears and next state is EVAL. Exactly PRE_CYCLES cycles are spent in PRE.
- State EVAL:
  - prechrg_o=0; ready_o=1; outputs stay at spacer.
  - Transfer condition is valid_i && ready_o.
  - DUAL_IN=0: on transfer, q_o<=d_i and qbar_o<=~d_i; next state is HOLD.
  - DUAL_IN=1: each bit pair (d_i[k], dbar_i[k]) is classified as:
    - 10 or 01: data.
    - 00: spacer (not yet evaluated).
    - 11: illegal.
  - DUAL_IN=1 capture rules on valid_i:
    - All pairs data: q_o<=d_i, qbar_o<=dbar_i, next state is HOLD.
    - Any pair 11: fault_o<=1, word is dropped, stay in EVAL.
    - Otherwise (some 00, no 11): no capture, stay in EVAL, no fault. Upstream keeps valid_i high.
- State HOLD:
  - valid_o=1; ready_o=0; q_o/qbar_o stable and complementary in every bit.
  - On ready_i=1: next state is PRE, and outputs return to spacer in the following cycle.
  - No backpressure limit; HOLD is held indefinitely.
- Latency and throughput:
  - Capture to valid_o is 1 cycle.
  - Minimum period per word is PRE_CYCLES+2 cycles (PRE, EVAL, HOLD).
- Rail invariant: no bit ever has q_o[k]=qbar_o[k]=1. In HOLD every bit is exactly one-hot.
- fault_o stays set until rst. Transfers continue normally after a fault.
- Simultaneous events:
  - valid_i in PRE or HOLD is ignored (ready_o=0).
  - ready_i in PRE or EVAL is ignored.
- Reset mid-operation: outputs go to spacer immediately (asynchronously) and any held word is lost.

Decomposition:
- Shared package wddl_pkg holds:
  - State enum (WDDL_PRE, WDDL_EVAL, WDDL_HOLD).
  - Rail-pair encodings (SPACER=2'b00, ONE=2'b10, ZERO=2'b01, ILLEGAL=2'b11).
  - Localparam for the precharge counter width, $clog2(16).
- One natural sub-module: wddl_phase_ctrl.
  - Contains the FSM plus precharge counter.
  - Outputs phase enables prechrg_o, ready_o and valid_o.
  - The rail datapath and checker stay in the top level.

Test Plan:
- Reset then idle, WIDTH=8, PRE_CYCLES=2 -> ready_o rises on the 3rd edge after rst release; q_o=qbar_o=0x00 throughout; prechrg_o=1 for exactly 2 cycles.
- DUAL_IN=0, d_i=0xA5, valid_i=1 in EVAL -> next cycle q_o=0xA5, qbar_o=0x5A, valid_o=1; ready_i=1 -> following cycle q_o=qbar_o=0x00, prechrg_o=1.
- Backpressure: ready_i=0 for 10 cycles in HOLD -> q_o/qbar_o unchanged, valid_o=1, ready_o=0; a second valid_i=1 with d_i=0xFF is ignored.
- DUAL_IN=1, d_i=0x0F, dbar_i=0xE0 (bit 4 spacer) -> no capture, fault_o=0. Then dbar_i=0xF0 -> capture q_o=0x0F, qbar_o=0xF0.
- DUAL_IN=1, d_i=0x01, dbar_i=0xFF (bit 0 illegal) -> fault_o=1 next cycle, no capture, still EVAL; a later legal word transfers normally and fault_o stays 1 until rst.
- Assert rst while in HOLD with q_o=0x3C -> q_o=qbar_o=0, valid_o=0, fault_o=0 without waiting for a clk edge.
